// File: rtl/gfx_pixel_pipe.sv
// Pixel fetch and composition for the video path. Generates the VRAM read
// address from beam position, captures three foreground and three background
// plane bytes per 8-pixel group, serialises them LSB first, and resolves each
// pixel through palette, plane mask and colour mask into 8-bit RGB.
module gfx_pixel_pipe #(
  parameter logic [8:0] HSTART = 9'd32,
  parameter logic [8:0] VSTART = 9'd16,
  parameter int         HACT   = 192,
  parameter int         VACT   = 184
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ce_pix,
  input  logic [8:0]  h,
  input  logic [8:0]  v,
  output logic [12:0] gfx_vaddr,
  input  logic [7:0]  fg1,
  input  logic [7:0]  fg2,
  input  logic [7:0]  fg3,
  input  logic [7:0]  bg1,
  input  logic [7:0]  bg2,
  input  logic [7:0]  bg3,
  input  logic [7:0]  p1,
  input  logic [7:0]  p2,
  input  logic [7:0]  p3,
  input  logic [7:0]  p4,
  input  logic [7:0]  p5,
  input  logic [7:0]  p6,
  input  logic [7:0]  mask,
  input  logic [7:0]  cmask,
  input  logic [7:0]  bgc,
  output logic [7:0]  red,
  output logic [7:0]  green,
  output logic [7:0]  blue
);

  localparam logic signed [9:0] L_HACT = $signed(10'(HACT));
  localparam logic signed [9:0] L_VACT = $signed(10'(VACT));

  // Beam position relative to the bitmap origin; signed so the left/top
  // border produces negative values instead of wrapping.
  logic signed [9:0] w_x;
  logic signed [9:0] w_y;
  logic signed [9:0] w_xf;
  logic              w_yact;
  logic              w_act;
  logic              w_trig;
  logic              w_load;
  logic [12:0]       w_addr;
  logic [5:0]        w_bits;
  logic [2:0]        w_fc;
  logic [2:0]        w_bc;
  logic [2:0]        w_col;

  logic [12:0]       r_vaddr;
  logic              r_fetch_p0;
  logic              r_fetch_p1;
  logic [5:0][7:0]   r_hold;
  logic [5:0][7:0]   r_shf;
  logic [2:0]        r_rgb;

  assign w_x    = $signed({1'b0, h}) - $signed({1'b0, HSTART});
  assign w_y    = $signed({1'b0, v}) - $signed({1'b0, VSTART});
  // Fetch runs two pixels ahead of the byte it serves.
  assign w_xf   = w_x + 10'sd2;
  assign w_yact = (w_y >= 10'sd0) && (w_y < L_VACT);
  assign w_act  = w_yact && (w_x >= 10'sd0) && (w_x < L_HACT);
  assign w_trig = ce_pix && w_yact && (w_xf >= 10'sd0) && (w_xf < L_HACT)
                  && (w_xf[2:0] == 3'd0);
  assign w_load = ce_pix && w_act && (w_x[2:0] == 3'd0);
  assign w_addr = 13'(w_y[7:0]) * 13'd24 + 13'(w_xf[7:3]);

  assign gfx_vaddr = r_vaddr;
  assign red       = {8{r_rgb[0]}};
  assign green     = {8{r_rgb[1]}};
  assign blue      = {8{r_rgb[2]}};

  // Stage p0: issue the VRAM address on a fetch trigger and track read latency.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_vaddr    <= '0;
      r_fetch_p0 <= 1'b0;
      r_fetch_p1 <= 1'b0;
    end else begin
      if (w_trig) r_vaddr <= w_addr;
      r_fetch_p0 <= w_trig;
      r_fetch_p1 <= r_fetch_p0;
    end
  end

  // Stage p1: capture the six plane bytes once the VRAM data is valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hold <= '0;
    end else if (r_fetch_p1) begin
      r_hold <= {bg3, bg2, bg1, fg3, fg2, fg1};
    end
  end

  // Stage p2: load the shifters at each byte boundary, else shift one pixel.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_shf <= '0;
    end else if (w_load) begin
      r_shf <= r_hold;
    end else if (ce_pix && w_act) begin
      for (int i = 0; i < 6; i++) r_shf[i] <= {1'b0, r_shf[i][7:1]};
    end
  end

  // Current pixel bit per plane: straight from the holding regs on a load.
  always_comb begin
    w_bits = '0;
    for (int i = 0; i < 6; i++) w_bits[i] = w_load ? r_hold[i][0] : r_shf[i][1];
  end

  // Resolve fg over bg over border colour, then apply the channel mask.
  always_comb begin
    w_fc  = w_bits[2:0] & mask[2:0];
    w_bc  = w_bits[5:3] & mask[5:3];
    w_col = bgc[2:0];
    if (w_act) begin
      if (w_fc != 3'd0)      w_col = {p3[w_fc], p2[w_fc], p1[w_fc]};
      else if (w_bc != 3'd0) w_col = {p6[w_bc], p5[w_bc], p4[w_bc]};
    end
    w_col = w_col & cmask[2:0];
  end

  // Stage p3: register the composed colour on each pixel clock.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rgb <= '0;
    end else if (ce_pix) begin
      r_rgb <= w_col;
    end
  end

endmodule

// File: tb/tb_gfx_pixel_pipe.sv
// Scoreboard bench for gfx_pixel_pipe: a VRAM model feeds the plane bytes,
// each pixel pushes its expected colour and address computed from the bitmap
// rules, and a monitor compares on the cycle after every pixel clock.
module tb_gfx_pixel_pipe;

  localparam int HS = 32;
  localparam int VS = 16;
  localparam int NB = 4416;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ce_pix = 1'b0;
  logic [8:0]  h = '0;
  logic [8:0]  v = '0;
  logic [12:0] gfx_vaddr;
  logic [7:0]  fg1, fg2, fg3, bg1, bg2, bg3;
  logic [7:0]  p1, p2, p3, p4, p5, p6;
  logic [7:0]  mask, cmask, bgc;
  logic [7:0]  red, green, blue;

  logic [7:0]  m_f1 [NB];
  logic [7:0]  m_f2 [NB];
  logic [7:0]  m_f3 [NB];
  logic [7:0]  m_b1 [NB];
  logic [7:0]  m_b2 [NB];
  logic [7:0]  m_b3 [NB];

  typedef struct {
    bit          chk;
    logic [2:0]  col;
    logic [12:0] addr;
  } exp_t;
  exp_t q[$];

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: last issued address, and whether correct data is in flight.
  int exp_addr  = 0;
  bit trig_seen = 0;
  bit col_ok    = 0;

  gfx_pixel_pipe dut (
    .clk(clk), .reset(reset), .ce_pix(ce_pix), .h(h), .v(v),
    .gfx_vaddr(gfx_vaddr),
    .fg1(fg1), .fg2(fg2), .fg3(fg3), .bg1(bg1), .bg2(bg2), .bg3(bg3),
    .p1(p1), .p2(p2), .p3(p3), .p4(p4), .p5(p5), .p6(p6),
    .mask(mask), .cmask(cmask), .bgc(bgc),
    .red(red), .green(green), .blue(blue)
  );

  always #5 clk = ~clk;

  // VRAM: one clock of read latency.
  always @(posedge clk) begin
    fg1 <= m_f1[gfx_vaddr];
    fg2 <= m_f2[gfx_vaddr];
    fg3 <= m_f3[gfx_vaddr];
    bg1 <= m_b1[gfx_vaddr];
    bg2 <= m_b2[gfx_vaddr];
    bg3 <= m_b3[gfx_vaddr];
  end

  function automatic logic [2:0] ref_col(input int hh, input int vv);
    int x, y, idx, b;
    logic [2:0] f, bb, c;
    x = hh - HS;
    y = vv - VS;
    c = bgc[2:0];
    if (x >= 0 && x < 192 && y >= 0 && y < 184) begin
      idx = y * 24 + x / 8;
      b   = x % 8;
      f   = {m_f3[idx][b], m_f2[idx][b], m_f1[idx][b]} & mask[2:0];
      bb  = {m_b3[idx][b], m_b2[idx][b], m_b1[idx][b]} & mask[5:3];
      if (f != 0)       c = {p3[f], p2[f], p1[f]};
      else if (bb != 0) c = {p6[bb], p5[bb], p4[bb]};
    end
    return c & cmask[2:0];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One pixel clock: drive beam position, push the expectation, idle 2 clks.
  task automatic pix(input int hh, input int vv);
    exp_t e;
    int x, y, xf;
    bit act;
    @(negedge clk);
    h = 9'(hh);
    v = 9'(vv);
    ce_pix = 1'b1;
    x  = hh - HS;
    y  = vv - VS;
    xf = x + 2;
    if (y >= 0 && y < 184 && xf >= 0 && xf < 192 && xf % 8 == 0) begin
      exp_addr  = y * 24 + xf / 8;
      trig_seen = 1;
    end
    act = (y >= 0 && y < 184 && x >= 0 && x < 192);
    if (act && x % 8 == 0 && trig_seen) col_ok = 1;
    e.chk  = !act || col_ok;
    e.col  = ref_col(hh, vv);
    e.addr = 13'(exp_addr);
    q.push_back(e);
    @(negedge clk);
    ce_pix = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("reset_rgb", {8'h0, red, green, blue}, 32'h0);
    check("reset_vaddr", {19'h0, gfx_vaddr}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    exp_addr  = 0;
    trig_seen = 0;
    col_ok    = 0;
  endtask

  task automatic rand_regs();
    p1 = 8'($urandom); p2 = 8'($urandom); p3 = 8'($urandom);
    p4 = 8'($urandom); p5 = 8'($urandom); p6 = 8'($urandom);
    mask = 8'($urandom); cmask = 8'($urandom); bgc = 8'($urandom);
  endtask

  // mode 0 plain, 1 flip p1 before x=4, 2 random register writes, 3 reset mid-line
  task automatic run_line(input int vv, input int mode);
    for (int hh = 0; hh < 240; hh++) begin
      if (mode == 1 && hh == HS + 4) p1 = ~p1;
      if (mode == 2 && $urandom_range(0, 7) == 0) rand_regs();
      pix(hh, vv);
      if (mode == 3 && hh == HS + 50) do_reset();
    end
  endtask

  task automatic set_row(input int y, input logic [7:0] f1v, input logic [7:0] b1v);
    for (int k = 0; k < 24; k++) begin
      m_f1[y*24+k] = f1v; m_f2[y*24+k] = 8'h00; m_f3[y*24+k] = 8'h00;
      m_b1[y*24+k] = b1v; m_b2[y*24+k] = 8'h00; m_b3[y*24+k] = 8'h00;
    end
  endtask

  // Monitor: after every pixel clock edge, pop and compare.
  initial begin
    exp_t e;
    logic ce_at;
    forever begin
      @(posedge clk);
      ce_at = ce_pix;
      @(negedge clk);
      if (ce_at) begin
        if (q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL scoreboard_empty: got output, expected none");
        end else begin
          e = q.pop_front();
          check("vaddr", {19'h0, gfx_vaddr}, {19'h0, e.addr});
          if (e.chk)
            check("rgb", {8'h0, red, green, blue},
                  {8'h0, {8{e.col[0]}}, {8{e.col[1]}}, {8{e.col[2]}}});
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < NB; i++) begin
      m_f1[i] = 8'($urandom); m_f2[i] = 8'($urandom); m_f3[i] = 8'($urandom);
      m_b1[i] = 8'($urandom); m_b2[i] = 8'($urandom); m_b3[i] = 8'($urandom);
    end
    rand_regs();
    mask = 8'h3F;
    cmask = 8'h07;
    repeat (3) @(negedge clk);
    check("init_rgb", {8'h0, red, green, blue}, 32'h0);
    check("init_vaddr", {19'h0, gfx_vaddr}, 32'h0);
    reset = 1'b0;

    run_line(VS - 1, 0);
    run_line(VS + 5, 0);
    run_line(VS + 183, 0);
    run_line(VS + 5, 1);
    run_line(VS + 7, 3);
    run_line(VS + 9, 2);
    run_line(VS + 100, 2);

    // Pixel order: only bit 0 of fg1 set in every byte.
    set_row(0, 8'h01, 8'h00);
    mask = 8'h3F; cmask = 8'h07; bgc = 8'h04;
    p1 = 8'h02; p2 = 8'h00; p3 = 8'h00;
    run_line(VS, 0);

    // Priority: fg colour 0 wins when enabled; bg shows when fg masked.
    set_row(1, 8'hFF, 8'hFF);
    p1 = 8'h00; p2 = 8'h00; p3 = 8'h00;
    p4 = 8'h02; p5 = 8'h00; p6 = 8'h00;
    mask = 8'h3F;
    run_line(VS + 1, 0);
    mask = 8'h38;
    run_line(VS + 1, 0);

    // Border with channel mask.
    bgc = 8'h07; cmask = 8'h05;
    run_line(VS + 184, 0);
    run_line(VS + 3, 0);

    repeat (6) @(negedge clk);
    check("scoreboard_drained", q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/gfx_pixel_pipe.md
Name: gfx_pixel_pipe

Overview:
Pixel fetch and composition stage for the RX-78 core, directly downstream of the six VRAM plane buffers and the palette/mask I/O registers. It generates the video-side VRAM read address from beam position and captures the three foreground and three background plane bytes. It serialises them into pixels and resolves each pixel through the palette, plane mask and colour mask into 8-bit RGB. The 192x184 bitmap is centred in the raster from the timing generator; everything outside it shows the background colour.

Parameters:
HSTART, 9'd32, h count of first active pixel column
VSTART, 9'd16, v count of first active line
HACT, 192, active pixels per line (24 bytes)
VACT, 184, active lines

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high
ce_pix  in  1  one-clk pulse per pixel; h/v change only on ce_pix cycles
h  in  9  horizontal count from timing generator
v  in  9  vertical count from timing generator
gfx_vaddr  out  13  video-side VRAM byte address, common to all six planes
fg1, fg2, fg3  in  8 each  foreground plane bytes, valid 1 clk after gfx_vaddr
bg1, bg2, bg3  in  8 each  background plane bytes, same timing
p1..p6  in  8 each  palette: p1/p2/p3 = fg R/G/B, p4/p5/p6 = bg R/G/B, bit index = colour code
mask  in  8  plane enables: [2:0] fg planes 1..3, [5:3] bg planes 1..3
cmask  in  8  channel enables: [0] R, [1] G, [2] B; [7:3] ignored
bgc  in  8  background colour: [0] R, [1] G, [2] B; [7:3] ignored
red, green, blue  out  8 each  registered pixel colour

Behaviour:
- Reset, synchronous active-high. gfx_vaddr=0. Holding regs, six shifters, red/green/blue=0. The first ce_pix after reset deassertion is processed normally.
- Requirement: ce_pix pulses are >=3 clk apart. The VRAM read latency is 1 clk.
- Window: x=h-HSTART, y=v-VSTART. Active when 0<=x<HACT and 0<=y<VACT. Use 10-bit signed compare; no wrap.
- Fetch, for k=0..23:
  - Trigger: ce_pix with h==HSTART+8k-2 and y active.
  - On that edge, register gfx_vaddr = y*24+k. Max is 183*24+23 = 4415; 13-bit, no overflow.
  - Exactly 2 clks after the trigger, capture fg1..3 and bg1..3 into six holding regs.
  - k=0 triggers at HSTART-2, before the window opens.
  - gfx_vaddr holds its last value between fetches and outside the window.
- Serialise:
  - Pixel order is LSB first: bit 0 of a byte is the leftmost pixel.
  - On ce_pix with x%8==0 (active): load the shifters from the holding regs, and use bit 0 of the holding regs for this pixel.
  - On other active ce_pix: shift right by 1, then use the new bit 0.
- Compose, per active pixel:
  - fc = {f3,f2,f1} & mask[2:0].
  - bc = {b3,b2,b1} & mask[5:3].
  - If fc!=0: R=p1[fc], G=p2[fc], B=p3[fc].
  - Else if bc!=0: R=p4[bc], G=p5[bc], B=p6[bc].
  - Else: R=bgc[0], G=bgc[1], B=bgc[2].
  - Each channel is then ANDed with its cmask bit.
- Inactive pixels (including blanking): colour = bgc[2:0] & cmask[2:0].
- Output: channel bit 1 -> 8'hFF, 0 -> 8'h00.
  - red/green/blue are registered on the ce_pix edge whose h is the pixel's h. Latency is 1 clk from the ce_pix cycle, and the values hold until the next ce_pix.
- Register sampling: p1..p6, mask, cmask, bgc are sampled at compose time. CPU writes take effect on the next ce_pix and are not latched per line.
- Reset mid-line: outputs go to 0 and the fetch is abandoned. The rest of that line shows stale/zero shifter data composed normally until the next fetch sequence; no lockup.
- Simultaneous fetch trigger and x%8==0 load cannot occur: they are 2 pixels apart.

Test Plan:
- Reset: assert reset 2 clks mid-line -> gfx_vaddr=0, red/green/blue=0 on the following clk; fetches resume at the next trigger.
- Address generation: v=VSTART+5, sweep h -> gfx_vaddr=120 at h=30, 121 at h=38, ... 143 at h=214; v=VSTART+183 -> 4392..4415.
- Pixel order/fg palette:
  - Setup: fg1=8'h01, others 0, mask=8'h3F, cmask=7, p1=8'h02, p2=0, p3=0.
  - x=0 -> red=FF, green=00, blue=00.
  - x=1..7 -> bgc colour.
- Priority and masking:
  - Setup: fg1=FF, bg1=FF, p1=0, p2=0, p3=0, p4=8'h02.
  - mask=3F -> all channels 00 (fg wins with colour 0).
  - mask=38 -> red=FF for every pixel.
- Border/cmask:
  - Setup: bgc=8'h07, cmask=8'h05.
  - h=HSTART-1 or v=VSTART+184 -> red=FF, green=00, blue=FF.
- Palette write mid-line: change p1 between pixels x=3 and x=4 -> colour changes exactly at x=4.
